// File: rtl/axi_wr_arbiter_if.sv
// Shared AXI4 write-channel bundle between NUM_M masters and one slave port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface axi_wr_arbiter_if #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic [NUM_M-1:0]          m_awvalid;
   logic [NUM_M-1:0]          m_awready;
   logic [NUM_M*ADDR_W-1:0]   m_awaddr;
   logic [NUM_M*8-1:0]        m_awlen;
   logic [NUM_M*ID_W-1:0]     m_awid;
   logic [NUM_M-1:0]          m_wvalid;
   logic [NUM_M-1:0]          m_wready;
   logic [NUM_M*DATA_W-1:0]   m_wdata;
   logic [NUM_M*DATA_W/8-1:0] m_wstrb;
   logic [NUM_M-1:0]          m_wlast;
   logic [NUM_M-1:0]          m_bvalid;
   logic [NUM_M-1:0]          m_bready;
   logic [NUM_M*2-1:0]        m_bresp;
   logic [NUM_M*ID_W-1:0]     m_bid;

   logic                      s_awvalid;
   logic                      s_awready;
   logic [ADDR_W-1:0]         s_awaddr;
   logic [7:0]                s_awlen;
   logic [ID_W-1:0]           s_awid;
   logic                      s_wvalid;
   logic                      s_wready;
   logic [DATA_W-1:0]         s_wdata;
   logic [DATA_W/8-1:0]       s_wstrb;
   logic                      s_wlast;
   logic                      s_bvalid;
   logic                      s_bready;
   logic [1:0]                s_bresp;
   logic [ID_W-1:0]           s_bid;

   modport slave (
      input  m_awvalid, m_awaddr, m_awlen, m_awid,
      input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
      input  s_awready, s_wready, s_bvalid, s_bresp, s_bid,
      output m_awready, m_wready, m_bvalid, m_bresp, m_bid,
      output s_awvalid, s_awaddr, s_awlen, s_awid,
      output s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready
   );

   modport master (
      output m_awvalid, m_awaddr, m_awlen, m_awid,
      output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
      output s_awready, s_wready, s_bvalid, s_bresp, s_bid,
      input  m_awready, m_wready, m_bvalid, m_bresp, m_bid,
      input  s_awvalid, s_awaddr, s_awlen, s_awid,
      input  s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready
   );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port among NUM_M masters,
// owning a single AW/W/B transaction at a time.
module axi_wr_arbiter #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   axi_wr_arbiter_if.slave  bus,
   output logic [NUM_M-1:0] grant,
   output logic             busy,
   output logic             wlast_err
);
   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam logic [IDX_W:0] NUM_M_C = (IDX_W + 1)'(NUM_M);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t            state;
   logic [IDX_W-1:0]  gidx;
   logic [IDX_W-1:0]  last_grant;
   logic [IDX_W-1:0]  winner;
   logic [IDX_W:0]    cand;
   logic              found;
   logic [7:0]        beat_cnt;
   logic [7:0]        len_q;

   logic              sel_awvalid;
   logic [ADDR_W-1:0] sel_awaddr;
   logic [7:0]        sel_awlen;
   logic [ID_W-1:0]   sel_awid;
   logic              sel_wvalid;
   logic [DATA_W-1:0] sel_wdata;
   logic [STRB_W-1:0] sel_wstrb;
   logic              sel_wlast;
   logic              sel_bready;

   logic              in_addr;
   logic              in_data;
   logic              in_resp;
   logic              aw_hs;
   logic              w_hs;
   logic              b_hs;
   logic              last_beat;

   // Search upward from the previous owner so every requester is reached within NUM_M grants.
   always_comb begin
      winner = last_grant;
      found  = 1'b0;
      cand   = '0;
      for (int i = 1; i <= NUM_M; i++) begin
         cand = {1'b0, last_grant} + (IDX_W + 1)'(i);
         if (cand >= NUM_M_C) cand = cand - NUM_M_C;
         if (!found && bus.m_awvalid[cand[IDX_W-1:0]]) begin
            winner = cand[IDX_W-1:0];
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_awvalid = 1'b0;
      sel_awaddr  = '0;
      sel_awlen   = '0;
      sel_awid    = '0;
      sel_wvalid  = 1'b0;
      sel_wdata   = '0;
      sel_wstrb   = '0;
      sel_wlast   = 1'b0;
      sel_bready  = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         if (gidx == IDX_W'(i)) begin
            sel_awvalid = bus.m_awvalid[i];
            sel_awaddr  = bus.m_awaddr[i*ADDR_W +: ADDR_W];
            sel_awlen   = bus.m_awlen[i*8 +: 8];
            sel_awid    = bus.m_awid[i*ID_W +: ID_W];
            sel_wvalid  = bus.m_wvalid[i];
            sel_wdata   = bus.m_wdata[i*DATA_W +: DATA_W];
            sel_wstrb   = bus.m_wstrb[i*STRB_W +: STRB_W];
            sel_wlast   = bus.m_wlast[i];
            sel_bready  = bus.m_bready[i];
         end
      end
   end

   // Handshake qualifiers are forced low while reset is held so no valid/ready leaks out.
   assign in_addr   = rst && (state == ADDR);
   assign in_data   = rst && (state == DATA);
   assign in_resp   = rst && (state == RESP);
   assign last_beat = (beat_cnt == len_q);

   assign bus.s_awvalid = in_addr && sel_awvalid;
   assign bus.s_awaddr  = sel_awaddr;
   assign bus.s_awlen   = sel_awlen;
   assign bus.s_awid    = sel_awid;
   assign bus.m_awready = grant & {NUM_M{in_addr && bus.s_awready}};

   assign bus.s_wvalid  = in_data && sel_wvalid;
   assign bus.s_wdata   = sel_wdata;
   assign bus.s_wstrb   = sel_wstrb;
   assign bus.s_wlast   = in_data && last_beat;
   assign bus.m_wready  = grant & {NUM_M{in_data && bus.s_wready}};

   assign bus.s_bready  = in_resp && sel_bready;
   assign bus.m_bvalid  = grant & {NUM_M{in_resp && bus.s_bvalid}};
   assign bus.m_bresp   = {NUM_M{bus.s_bresp}};
   assign bus.m_bid     = {NUM_M{bus.s_bid}};

   assign aw_hs = in_addr && sel_awvalid && bus.s_awready;
   assign w_hs  = in_data && sel_wvalid && bus.s_wready;
   assign b_hs  = in_resp && bus.s_bvalid && sel_bready;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= '0;
         gidx       <= '0;
         last_grant <= IDX_W'(NUM_M - 1);
         beat_cnt   <= '0;
         len_q      <= '0;
         wlast_err  <= 1'b0;
      end else begin
         wlast_err <= 1'b0;
         case (state)
            IDLE: begin
               if (|bus.m_awvalid) begin
                  gidx  <= winner;
                  grant <= NUM_M'(1) << winner;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (aw_hs) begin
                  len_q    <= sel_awlen;
                  beat_cnt <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  beat_cnt  <= beat_cnt + 8'd1;
                  wlast_err <= (sel_wlast != last_beat);
                  if (last_beat) state <= RESP;
               end
            end
            RESP: begin
               if (b_hs) begin
                  last_grant <= gidx;
                  grant      <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
Round-robin write-channel arbiter that shares one AXI4 slave write port (AW/W/B) among NUM_M requesting masters in the AXI VIP environment. It owns one write transaction at a time, from AW grant through WLAST to the B handshake. It sits between the bench's master agents and the axi_slave DUT, and it exposes grant and protocol-error status for the scoreboard and assertions.

Parameters:
NUM_M, 2, number of requesting masters (2..8)
ADDR_W, 32, AW address width
DATA_W, 32, W data width; strobe width is DATA_W/8
ID_W, 4, AWID/BID width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
m_awvalid  in  NUM_M  per-master AWVALID
m_awready  out  NUM_M  per-master AWREADY
m_awaddr  in  NUM_M*ADDR_W  flattened; master i at [i*ADDR_W +: ADDR_W]
m_awlen  in  NUM_M*8  flattened AWLEN
m_awid  in  NUM_M*ID_W  flattened AWID
m_wvalid  in  NUM_M  per-master WVALID
m_wready  out  NUM_M  per-master WREADY
m_wdata  in  NUM_M*DATA_W  flattened WDATA
m_wstrb  in  NUM_M*DATA_W/8  flattened WSTRB
m_wlast  in  NUM_M  per-master WLAST
m_bvalid  out  NUM_M  per-master BVALID
m_bready  in  NUM_M  per-master BREADY
m_bresp  out  NUM_M*2  BRESP, replicated to all slices
m_bid  out  NUM_M*ID_W  BID, replicated to all slices
s_awvalid/s_awready/s_awaddr/s_awlen/s_awid  out/in/out/out/out  1/1/ADDR_W/8/ID_W  slave AW channel
s_wvalid/s_wready/s_wdata/s_wstrb/s_wlast  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  slave W channel
s_bvalid/s_bready/s_bresp/s_bid  in/out/in/in  1/1/2/ID_W  slave B channel
grant  out  NUM_M  one-hot owner; zero in IDLE
busy  out  1  high in any state other than IDLE
wlast_err  out  1  one-cycle pulse on an m_wlast mismatch

Behaviour:
- State machine states: IDLE, ADDR, DATA, RESP. State, grant, last_grant, beat_cnt and len_q are registered.
- Reset (rst==0 at a clk edge):
  - Next state is IDLE, grant=0, beat_cnt=0, last_grant=NUM_M-1 so master 0 has first priority, wlast_err=0.
  - Every valid/ready output is 0, whether driven combinationally or by a register.
  - Reset asserted mid-burst aborts the transaction with no completion. The bench re-initialises the slave.
- IDLE:
  - If any m_awvalid is set, the winner is the first set bit searching upward from last_grant+1, wrapping modulo NUM_M.
  - Next cycle: grant=winner and state=ADDR. Latency from request to s_awvalid is 1 cycle.
  - If no m_awvalid is set, remain in IDLE.
- ADDR:
  - s_aw* is muxed from master g, with s_awvalid=m_awvalid[g].
  - m_awready[g]=s_awready; all other m_awready are 0.
  - On s_awvalid&&s_awready: len_q<=awlen, beat_cnt<=0, go to DATA.
  - The arbiter does not check whether a master withdraws AWVALID; the assertion module flags that.
- DATA:
  - s_wvalid=m_wvalid[g], s_wdata/s_wstrb come from master g, and m_wready[g]=s_wready.
  - s_wlast is driven as (beat_cnt==len_q), not from the master.
  - On each W handshake beat_cnt increments, using an 8-bit counter.
  - On a handshake with beat_cnt==len_q, go to RESP.
  - wlast_err pulses on any handshake where m_wlast[g] != (beat_cnt==len_q). The transfer is unaffected.
- RESP:
  - m_bvalid[g]=s_bvalid, s_bready=m_bready[g], and bresp/bid pass through.
  - On s_bvalid&&s_bready: last_grant<=g, grant<=0, go to IDLE.
- Back-to-back transfers: each B handshake is followed by 1 IDLE cycle before the next grant.
- A non-granted master sees awready, wready and bvalid all at 0 for the whole transaction.
- The search covers all NUM_M bits, so a requester cannot starve. Any continuously waiting requester is granted within NUM_M-1 transactions.
- AWLEN=0 is a single beat with s_wlast high on beat 0. AWLEN=255 is 256 beats, and beat_cnt must not wrap before the final handshake.
- Simultaneous s_awready and a new request from another master: the new request is ignored until the arbiter returns to IDLE.

Test Plan:
- Reset, then m_awvalid=2'b11 with both AWLEN=0 -> grant=01 one cycle after request; master 0 completes first, then grant=10; total 2 bursts, each with 1 IDLE gap.
- Master 1 alone, AWLEN=3, s_wready toggled every other cycle -> exactly 4 W handshakes; s_wlast only on the 4th; BID/BRESP=OKAY delivered only to m_bvalid[1].
- Master 0 requesting continuously while master 1 requests once -> grant order 0,1,0; master 1 waits at most one transaction.
- Master 0 AWLEN=2 but asserting m_wlast on beat 1 -> wlast_err=1 for that one cycle; 3 beats still transferred, s_wlast on beat 2.
- rst=0 asserted during DATA at beat 5 of AWLEN=7 -> next cycle state=IDLE, grant=0, busy=0, every valid/ready=0; first grant after release goes to master 0.
- AWLEN=255 single burst -> 256 beats, s_wlast only on the last beat, B accepted, return to IDLE.
